// File: rtl/spi_slave_frame.sv
// spi_slave_frame: SPI slave frame receiver with read-data serialiser, abort and timeout detection
//   clk         SPI bit clock, all sampling on the rising edge
//   rst_n       asynchronous active-low reset
//   ss_n        slave select, active low
//   mosi        serial data in
//   miso        serial data out, 0 when not transmitting
//   rx_data     last accepted {cmd, payload} frame
//   rx_valid    one-cycle pulse when rx_data updates
//   tx_data     read data from the memory side
//   tx_valid    tx_data valid, sampled only while waiting to transmit
//   busy        high whenever the FSM is not idle
//   frame_abort one-cycle pulse when ss_n rises mid-frame
//   cmd_err     one-cycle pulse on orphan RD_DATA or tx timeout
module spi_slave_frame #(
    parameter int DATA_W     = 8,
    parameter int MSB_FIRST  = 1,
    parameter int TX_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ss_n,
    input  logic                mosi,
    output logic                miso,
    output logic [DATA_W+1:0]   rx_data,
    output logic                rx_valid,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_valid,
    output logic                busy,
    output logic                frame_abort,
    output logic                cmd_err
);
    localparam int FRAME_W = DATA_W + 2;
    localparam int MAXC    = FRAME_W > TX_TIMEOUT ? FRAME_W : TX_TIMEOUT;
    localparam int CW      = $clog2(MAXC + 1);
    localparam bit MSB     = MSB_FIRST != 0;
    typedef enum logic [2:0] {IDLE, RX, WAIT_TX, TX, DONE} state_t;
    state_t state, state_n;
    logic [FRAME_W-1:0] sh, sh_n, frame, rx_data_n;
    logic [DATA_W-1:0] txsh, txsh_n;
    logic [CW-1:0] cnt, cnt_n, tcnt, tcnt_n;
    logic miso_n, rx_valid_n, cmd_err_n, abort_n, rd_pend, rd_pend_n;
    logic [1:0] cmd;
    assign frame = MSB ? {sh[FRAME_W-2:0], mosi} : {mosi, sh[FRAME_W-1:1]};
    assign cmd   = frame[FRAME_W-1 -: 2];
    assign busy  = state != IDLE;
    always_comb begin
        state_n    = state;
        sh_n       = sh;
        cnt_n      = cnt;
        tcnt_n     = tcnt;
        txsh_n     = txsh;
        miso_n     = 1'b0;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        cmd_err_n  = 1'b0;
        abort_n    = 1'b0;
        rd_pend_n  = rd_pend;
        if (ss_n) begin
            // Deselect wins over everything, including the last RX bit edge
            state_n = IDLE;
            cnt_n   = '0;
            tcnt_n  = '0;
            abort_n = state == RX || state == WAIT_TX || state == TX;
        end else begin
            case (state)
                IDLE: begin
                    sh_n    = frame;
                    cnt_n   = CW'(1);
                    state_n = RX;
                end
                RX: begin
                    sh_n  = frame;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(FRAME_W - 1)) begin
                        state_n = DONE;
                        if (cmd == 2'b11 && !rd_pend) cmd_err_n = 1'b1;
                        else begin
                            rx_data_n  = frame;
                            rx_valid_n = 1'b1;
                            if (cmd == 2'b10) rd_pend_n = 1'b1;
                            if (cmd == 2'b11) begin
                                rd_pend_n = 1'b0;
                                tcnt_n    = '0;
                                state_n   = WAIT_TX;
                            end
                        end
                    end
                end
                WAIT_TX: begin
                    if (tx_valid) begin
                        miso_n  = MSB ? tx_data[DATA_W-1] : tx_data[0];
                        txsh_n  = MSB ? tx_data << 1 : tx_data >> 1;
                        tcnt_n  = CW'(1);
                        state_n = TX;
                    end else if (TX_TIMEOUT > 0) begin
                        // tcnt counts idle WAIT_TX edges; the TX_TIMEOUT-th one gives up
                        if (tcnt == CW'(TX_TIMEOUT - 1)) begin
                            cmd_err_n = 1'b1;
                            state_n   = DONE;
                        end else tcnt_n = tcnt + CW'(1);
                    end
                end
                TX: begin
                    if (tcnt == CW'(DATA_W)) state_n = DONE;
                    else begin
                        miso_n = MSB ? txsh[DATA_W-1] : txsh[0];
                        txsh_n = MSB ? txsh << 1 : txsh >> 1;
                        tcnt_n = tcnt + CW'(1);
                    end
                end
                DONE: state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sh          <= '0;
            cnt         <= '0;
            tcnt        <= '0;
            txsh        <= '0;
            miso        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            cmd_err     <= 1'b0;
            frame_abort <= 1'b0;
            rd_pend     <= 1'b0;
        end else begin
            state       <= state_n;
            sh          <= sh_n;
            cnt         <= cnt_n;
            tcnt        <= tcnt_n;
            txsh        <= txsh_n;
            miso        <= miso_n;
            rx_data     <= rx_data_n;
            rx_valid    <= rx_valid_n;
            cmd_err     <= cmd_err_n;
            frame_abort <= abort_n;
            rd_pend     <= rd_pend_n;
        end
    end
endmodule

// File: tb/tb_spi_slave_frame.sv
// tb_spi_slave_frame: directed checks of spi_slave_frame in MSB-first and LSB-first builds
module tb_spi_slave_frame;
    logic clk = 1'b0, rst_n, ss_n, mosi, tx_valid;
    logic [7:0] tx_data;
    logic miso_a, rxv_a, busy_a, abort_a, err_a;
    logic miso_b, rxv_b, busy_b, abort_b, err_b;
    logic [9:0] rxd_a, rxd_b;
    int total = 0, bad = 0;
    logic [7:0] exp_tx;
    always #5 clk = ~clk;
    spi_slave_frame #(.DATA_W(8), .MSB_FIRST(1), .TX_TIMEOUT(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi), .miso(miso_a),
        .rx_data(rxd_a), .rx_valid(rxv_a), .tx_data(tx_data), .tx_valid(tx_valid),
        .busy(busy_a), .frame_abort(abort_a), .cmd_err(err_a));
    spi_slave_frame #(.DATA_W(8), .MSB_FIRST(0), .TX_TIMEOUT(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi), .miso(miso_b),
        .rx_data(rxd_b), .rx_valid(rxv_b), .tx_data(tx_data), .tx_valid(tx_valid),
        .busy(busy_b), .frame_abort(abort_b), .cmd_err(err_b));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(negedge clk);
    endtask
    task automatic send(input logic [9:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ss_n = 1'b0;
            mosi = f[9-i];
            tick;
            if (i < n - 1) begin
                check("rxv_early", rxv_a, 0);
                check("miso_rx", miso_a, 0);
            end
        end
    endtask
    task automatic deselect;
        ss_n = 1'b1;
        tick;
    endtask
    initial begin
        rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        tick;
        tick;
        check("rst_rxd", rxd_a, 0);
        check("rst_rxv", rxv_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_miso", miso_a, 0);
        check("rst_err", err_a, 0);
        check("rst_abort", abort_a, 0);
        rst_n = 1'b1;
        tick;
        send(10'h0A5, 10);
        check("t1_rxv", rxv_a, 1);
        check("t1_rxd", rxd_a, 10'h0A5);
        check("t1_busy", busy_a, 1);
        deselect;
        check("t1_rxv_pulse", rxv_a, 0);
        check("t1_busy_idle", busy_a, 0);
        check("t1_no_abort", abort_a, 0);
        send(10'h23C, 10);
        check("t2_addr_rxv", rxv_a, 1);
        check("t2_addr_rxd", rxd_a, 10'h23C);
        deselect;
        send(10'h300, 10);
        check("t2_data_rxv", rxv_a, 1);
        check("t2_data_rxd", rxd_a, 10'h300);
        check("t2_data_err", err_a, 0);
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        exp_tx = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            check("t2_miso_bit", miso_a, exp_tx[7-i]);
            tick;
        end
        check("t2_miso_end", miso_a, 0);
        check("t2_busy_done", busy_a, 1);
        deselect;
        check("t2_no_abort", abort_a, 0);
        send(10'h3FF, 10);
        check("t3_err", err_a, 1);
        check("t3_rxv", rxv_a, 0);
        check("t3_rxd_kept", rxd_a, 10'h300);
        check("t3_miso", miso_a, 0);
        deselect;
        check("t3_err_pulse", err_a, 0);
        send(10'h1F0, 5);
        deselect;
        check("t4_abort", abort_a, 1);
        check("t4_busy", busy_a, 0);
        check("t4_rxv", rxv_a, 0);
        tick;
        check("t4_abort_pulse", abort_a, 0);
        send(10'h1F0, 10);
        check("t4_rxv_full", rxv_a, 1);
        check("t4_rxd_full", rxd_a, 10'h1F0);
        deselect;
        send(10'h155, 9);
        ss_n = 1'b1;
        mosi = 1'b1;
        tick;
        check("lastbit_abort", abort_a, 1);
        check("lastbit_rxv", rxv_a, 0);
        check("lastbit_rxd", rxd_a, 10'h1F0);
        send(10'h200, 10);
        deselect;
        send(10'h300, 10);
        check("t5_rxv", rxv_a, 1);
        for (int j = 1; j <= 16; j++) begin
            tick;
            check("t5_err_cycle", err_a, j == 16);
            check("t5_miso", miso_a, 0);
        end
        check("t5_busy", busy_a, 1);
        tick;
        check("t5_err_pulse", err_a, 0);
        deselect;
        check("t5_done_no_abort", abort_a, 0);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        send(10'b1010010100, 10);
        check("t6_rxv", rxv_b, 1);
        check("t6_rxd", rxd_b, 10'h0A5);
        deselect;
        send(10'b0000000001, 10);
        check("t6_addr_rxd", rxd_b, 10'h200);
        deselect;
        send(10'b0000000011, 10);
        check("t6_data_rxd", rxd_b, 10'h300);
        check("t6_data_err", err_b, 0);
        tx_data = 8'h03;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        check("t6_miso_b0", miso_b, 1);
        tick;
        check("t6_miso_b1", miso_b, 1);
        tick;
        check("t6_miso_b2", miso_b, 0);
        check("t6_busy_tx", busy_b, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_miso", miso_b, 0);
        check("t6_rst_busy", busy_b, 0);
        check("t6_rst_rxv", rxv_b, 0);
        check("t6_rst_rxd", rxd_b, 0);
        tick;
        rst_n = 1'b1;
        deselect;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
